// File: rtl/load_pulse_rx_pkg.sv
// load_pulse_rx_pkg: shared constants for the Load strobe receiver.
// State encoding, default timing parameters and counter widths.
package load_pulse_rx_pkg;

    localparam int CNT_W       = 10;
    localparam int PEND_W      = 3;
    localparam int HOLD_MS_DEF = 120;
    localparam int GAP_MS_DEF  = 30;
    localparam int QMAX_DEF    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Terminal count for an N-tick phase; a zero-length phase is never
    // entered, so its terminal value is irrelevant.
    function automatic logic [CNT_W-1:0] last_count(input int ms);
        return (ms > 0) ? CNT_W'(ms - 1) : '0;
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// tick_edge_sync: two-flop synchroniser plus rising-edge detector.
// Ports: clk, rst_n, tick_level (async level in), tick_pulse (1-clk pulse).
module tick_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_level,
    output logic tick_pulse
);

    logic sync1;
    logic sync2;
    logic old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            old   <= 1'b0;
        end else begin
            sync1 <= tick_level;
            sync2 <= sync1;
            old   <= sync2;
        end
    end

    assign tick_pulse = sync2 & ~old;

endmodule

// File: rtl/load_pulse_rx.sv
// load_pulse_rx: turns Load strobes into timed flap commands with a
// cool-down gap and a saturating queue of pending presses.
// Ports: clk, rst_n, tick_1ms (1 ms level), load_in (strobe) ->
//   flap_out, busy, pending[2:0], flap_start, drop_pulse (all registered).
// Build option: define LOAD_RX_RETRIGGER_EN so a strobe during HOLD
//   restarts the flap timer instead of queuing.
module load_pulse_rx
    import load_pulse_rx_pkg::*;
#(
    parameter int HOLD_MS = HOLD_MS_DEF,
    parameter int GAP_MS  = GAP_MS_DEF,
    parameter int QMAX    = QMAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1ms,
    input  logic              load_in,
    output logic              flap_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              flap_start,
    output logic              drop_pulse
);

    localparam logic [CNT_W-1:0]  HOLD_LAST = last_count(HOLD_MS);
    localparam logic [CNT_W-1:0]  GAP_LAST  = last_count(GAP_MS);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(QMAX);
    // With no cool-down the flap returns straight to IDLE.
    localparam state_t HOLD_EXIT = (GAP_MS == 0) ? ST_IDLE : ST_GAP;

    logic ms_tick;

    tick_edge_sync u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_level (tick_1ms),
        .tick_pulse (ms_tick)
    );

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic              start_d;
    logic              drop_d;
    logic              q_room;

    assign q_room = (pend_q < PEND_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        start_d = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_in || (pend_q != '0)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    start_d = 1'b1;
                    // A fresh strobe is served directly; otherwise
                    // the oldest queued press is consumed.
                    if (!load_in) begin
                        pend_d = pend_q - 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (ms_tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = HOLD_EXIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef LOAD_RX_RETRIGGER_EN
                // Re-press extends the flap; overrides a coincident end.
                if (load_in) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
`else
                if (load_in) begin
                    if (q_room) begin
                        pend_d = pend_q + 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
`endif
            end
            ST_GAP: begin
                if (ms_tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (load_in) begin
                    if (q_room) begin
                        pend_d = pend_q + 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            flap_out   <= 1'b0;
            busy       <= 1'b0;
            flap_start <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            flap_out   <= (state_d == ST_HOLD);
            busy       <= (state_d != ST_IDLE);
            flap_start <= start_d;
            drop_pulse <= drop_d;
        end
    end

    assign pending = pend_q;

endmodule

// File: tb/tb_load_pulse_rx.sv
// tb_load_pulse_rx: directed self-checking bench for load_pulse_rx
// with HOLD_MS=4, GAP_MS=2, QMAX=3 and a 20-clk millisecond.
module tb_load_pulse_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1ms;
    logic       load_in;
    logic       flap_out;
    logic       busy;
    logic [2:0] pending;
    logic       flap_start;
    logic       drop_pulse;

    int passed = 0;
    int total  = 0;
    int starts = 0;
    int drops  = 0;

    load_pulse_rx #(
        .HOLD_MS (4),
        .GAP_MS  (2),
        .QMAX    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1ms   (tick_1ms),
        .load_in    (load_in),
        .flap_out   (flap_out),
        .busy       (busy),
        .pending    (pending),
        .flap_start (flap_start),
        .drop_pulse (drop_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (flap_start) starts++;
        if (drop_pulse) drops++;
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One millisecond: level high 10 clk, low 10 clk.
    task automatic ms_step();
        tick_1ms = 1'b1;
        clk_n(10);
        tick_1ms = 1'b0;
        clk_n(10);
    endtask

    task automatic pulse_load();
        load_in = 1'b1;
        clk_n(1);
        load_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (!busy && pending == 3'd0) break;
            ms_step();
        end
        clk_n(2);
        total++;
        if (busy !== 1'b0 || pending !== 3'd0)
            $display("FAIL %s_drain busy=%b pending=%0d exp idle/0",
                     tag, busy, pending);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tick_1ms = 1'b0;
        load_in  = 1'b0;
        clk_n(3);
        total++;
        if ({flap_out, busy, flap_start, drop_pulse} !== 4'b0)
            $display("FAIL rst_outs got=%b exp=0000",
                     {flap_out, busy, flap_start, drop_pulse});
        else passed++;
        total++;
        if (pending !== 3'd0)
            $display("FAIL rst_pending got=%0d exp=0", pending);
        else passed++;
        rst_n = 1'b1;
        clk_n(2);
        total++;
        if ({flap_out, busy, pending} !== 5'b0)
            $display("FAIL rst_release got=%b exp=0",
                     {flap_out, busy, pending});
        else passed++;
    endtask

    task automatic test_single();
        int s0;
        clk_n(10);
        s0 = starts;
        pulse_load();
        total++;
        if ({flap_start, flap_out, busy} !== 3'b111)
            $display("FAIL single_lat got=%b exp=111",
                     {flap_start, flap_out, busy});
        else passed++;
        clk_n(1);
        total++;
        if (flap_start !== 1'b0)
            $display("FAIL single_start_w got=%b exp=0", flap_start);
        else passed++;
        repeat (3) ms_step();
        total++;
        if (flap_out !== 1'b1)
            $display("FAIL single_hold3 got=%b exp=1", flap_out);
        else passed++;
        ms_step();
        total++;
        if ({flap_out, busy} !== 2'b01)
            $display("FAIL single_gap got=%b exp=01", {flap_out, busy});
        else passed++;
        ms_step();
        total++;
        if (busy !== 1'b1)
            $display("FAIL single_gap1 got=%b exp=1", busy);
        else passed++;
        ms_step();
        total++;
        if ({busy, pending} !== 4'b0)
            $display("FAIL single_idle got=%b exp=0000", {busy, pending});
        else passed++;
        total++;
        if (starts - s0 !== 1)
            $display("FAIL single_starts got=%0d exp=1", starts - s0);
        else passed++;
    endtask

    task automatic test_queue3();
        int s0;
        s0 = starts;
        pulse_load();
        clk_n(1);
        for (int i = 1; i <= 3; i++) begin
            pulse_load();
            total++;
            if (pending !== 3'(i))
                $display("FAIL q3_pend%0d got=%0d exp=%0d", i, pending, i);
            else passed++;
            clk_n(1);
        end
        repeat (6) ms_step();
        total++;
        if ({flap_out, pending} !== {1'b1, 3'd2})
            $display("FAIL q3_b2b got=%b exp=1010", {flap_out, pending});
        else passed++;
        drain("q3");
        total++;
        if (starts - s0 !== 4)
            $display("FAIL q3_starts got=%0d exp=4", starts - s0);
        else passed++;
    endtask

    task automatic test_drop();
        int s0;
        int d0;
        s0 = starts;
        d0 = drops;
        pulse_load();
        clk_n(1);
        for (int i = 1; i <= 5; i++) begin
            pulse_load();
            total++;
            if (pending !== 3'((i > 3) ? 3 : i) || drop_pulse !== (i > 3))
                $display("FAIL drop_s%0d got p=%0d d=%b exp p=%0d d=%b",
                         i, pending, drop_pulse,
                         (i > 3) ? 3 : i, (i > 3));
            else passed++;
            clk_n(1);
        end
        total++;
        if (drop_pulse !== 1'b0)
            $display("FAIL drop_width got=%b exp=0", drop_pulse);
        else passed++;
        drain("drop");
        total++;
        if (drops - d0 !== 2)
            $display("FAIL drop_count got=%0d exp=2", drops - d0);
        else passed++;
        total++;
        if (starts - s0 !== 4)
            $display("FAIL drop_starts got=%0d exp=4", starts - s0);
        else passed++;
    endtask

    task automatic test_load_on_gap_tick();
        pulse_load();
        repeat (5) ms_step();
        tick_1ms = 1'b1;
        clk_n(2);
        load_in = 1'b1;
        clk_n(1);
        load_in = 1'b0;
        total++;
        if ({busy, flap_out, pending} !== {2'b00, 3'd1})
            $display("FAIL gaptick_idle got=%b exp=00001",
                     {busy, flap_out, pending});
        else passed++;
        clk_n(1);
        total++;
        if ({flap_start, flap_out, pending} !== {2'b11, 3'd0})
            $display("FAIL gaptick_start got=%b exp=11000",
                     {flap_start, flap_out, pending});
        else passed++;
        clk_n(6);
        tick_1ms = 1'b0;
        clk_n(10);
        drain("gaptick");
    endtask

    task automatic test_reset_mid();
        int s0;
        pulse_load();
        clk_n(1);
        pulse_load();
        repeat (2) ms_step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({flap_out, busy, pending} !== 5'b0)
            $display("FAIL midrst_async got=%b exp=00000",
                     {flap_out, busy, pending});
        else passed++;
        clk_n(2);
        rst_n = 1'b1;
        clk_n(2);
        s0 = starts;
        pulse_load();
        total++;
        if ({flap_start, flap_out, busy} !== 3'b111)
            $display("FAIL midrst_restart got=%b exp=111",
                     {flap_start, flap_out, busy});
        else passed++;
        drain("midrst");
        total++;
        if (starts - s0 !== 1)
            $display("FAIL midrst_starts got=%0d exp=1", starts - s0);
        else passed++;
    endtask

    task automatic test_hold_press();
        pulse_load();
        repeat (3) ms_step();
        pulse_load();
`ifdef LOAD_RX_RETRIGGER_EN
        total++;
        if ({flap_out, pending} !== {1'b1, 3'd0})
            $display("FAIL retrig_press got=%b exp=1000",
                     {flap_out, pending});
        else passed++;
        repeat (3) ms_step();
        total++;
        if (flap_out !== 1'b1)
            $display("FAIL retrig_ext got=%b exp=1", flap_out);
        else passed++;
        ms_step();
        total++;
        if ({flap_out, pending} !== 4'b0)
            $display("FAIL retrig_end got=%b exp=0000", {flap_out, pending});
        else passed++;
`else
        total++;
        if ({flap_out, pending} !== {1'b1, 3'd1})
            $display("FAIL hold_press got=%b exp=1001",
                     {flap_out, pending});
        else passed++;
        ms_step();
        total++;
        if ({flap_out, busy} !== 2'b01)
            $display("FAIL hold_noext got=%b exp=01", {flap_out, busy});
        else passed++;
`endif
        drain("holdpress");
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue3();
        test_drop();
        test_load_on_gap_tick();
        test_reset_mid();
        test_hold_press();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
